// File: rtl/arcade_key_mapper.sv
// arcade_key_mapper
// Maps PS/2 key events and joystick bits onto active-low arcade buttons.
// Each button has two key slots tracked independently, plus an optional
// joystick source. Selected buttons get a minimum asserted width (coin).
// Optional autofire is compiled in when KEYMAP_AUTOFIRE_EN is defined;
// the default build has no autofire counters and ignores AF_MASK, AF_HALF
// and af_en.
module arcade_key_mapper #(
    parameter int unsigned         N_BTN        = 8,
    parameter logic [N_BTN*20-1:0] KEYMAP       = '0,
    parameter logic [N_BTN*5-1:0]  JOYMAP       = {N_BTN{5'h1F}},
    parameter logic [N_BTN-1:0]    COIN_MASK    = '0,
    parameter int unsigned         COIN_MIN_CYC = 250000,
    parameter logic [N_BTN-1:0]    AF_MASK      = '0,
    parameter int unsigned         AF_HALF      = 1250000
) (
    input  logic             clk_sys,
    input  logic             RESET_L,
    input  logic [10:0]      ps2_key,
    input  logic [15:0]      joy,
    input  logic             clr,
    input  logic             af_en,
    output logic [N_BTN-1:0] btn_l,
    output logic             btn_any
);

    localparam logic [23:0] COIN_LOAD = 24'(COIN_MIN_CYC - 1);

    logic                   old_strobe;
    logic                   primed;
    logic                   key_event;
    logic [2*N_BTN-1:0]     slot_hit;
    logic [2*N_BTN-1:0]     key_state;
    logic [N_BTN-1:0]       raw;
    logic [N_BTN-1:0]       af_out;
    logic [N_BTN-1:0]       stage_prev;
    logic [23:0]            coin_cnt [N_BTN];
    logic [N_BTN-1:0]       btn_out;

    // Track the strobe every cycle; the first cycle after reset only primes it
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            old_strobe <= 1'b0;
            primed     <= 1'b0;
        end else begin
            old_strobe <= ps2_key[10];
            primed     <= 1'b1;
        end
    end

    // A key event is a strobe toggle after priming, suppressed while clearing
    assign key_event = primed && (ps2_key[10] != old_strobe) && !clr;

    // Compare the incoming code against every slot; zero entries never match
    always_comb begin
        slot_hit = '0;
        for (int k = 0; k < 2*N_BTN; k++) begin
            slot_hit[k] = (KEYMAP[k*10 +: 9] != 9'd0)
                       && (ps2_key[7:0] == KEYMAP[k*10 +: 8])
                       && (KEYMAP[k*10+9] || (ps2_key[8] == KEYMAP[k*10+8]));
        end
    end

    // Held-key state per slot; all matching slots follow the pressed flag
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            key_state <= '0;
        end else if (clr) begin
            key_state <= '0;
        end else if (key_event) begin
            key_state <= (key_state & ~slot_hit) | (slot_hit & {2*N_BTN{ps2_key[9]}});
        end
    end

    // Combine both key slots with the joystick bit; index >= 16 means no source
    always_comb begin
        raw = '0;
        for (int i = 0; i < N_BTN; i++) begin
            raw[i] = key_state[2*i] | key_state[2*i+1]
                   | (~JOYMAP[i*5+4] & joy[JOYMAP[i*5 +: 4]]);
        end
    end

`ifdef KEYMAP_AUTOFIRE_EN
    localparam logic [23:0] AF_LAST = 24'(AF_HALF - 1);

    logic [23:0]      af_cnt [N_BTN];
    logic [N_BTN-1:0] af_phase;

    // Autofire phase counters restart whenever the button is not firing
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int i = 0; i < N_BTN; i++) af_cnt[i] <= '0;
            af_phase <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!raw[i] || !af_en || !AF_MASK[i]) begin
                    af_cnt[i]   <= '0;
                    af_phase[i] <= 1'b0;
                end else if (af_cnt[i] == AF_LAST) begin
                    af_cnt[i]   <= '0;
                    af_phase[i] <= ~af_phase[i];
                end else begin
                    af_cnt[i]   <= af_cnt[i] + 24'd1;
                end
            end
        end
    end

    // Autofire gates the held button off during its odd half-periods
    always_comb begin
        af_out = raw & ~({N_BTN{af_en}} & AF_MASK & af_phase);
    end
`else
    logic [N_BTN+24:0] unused_af;
    assign unused_af = {af_en, AF_MASK, AF_HALF[23:0]};

    // Without autofire the held state passes straight through
    always_comb begin
        af_out = raw;
    end
`endif

    // Coin stretch counters reload on every rising edge and run down to zero
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            stage_prev <= '0;
            for (int i = 0; i < N_BTN; i++) coin_cnt[i] <= '0;
        end else begin
            stage_prev <= af_out;
            for (int i = 0; i < N_BTN; i++) begin
                if (af_out[i] && !stage_prev[i]) begin
                    coin_cnt[i] <= COIN_LOAD;
                end else if (coin_cnt[i] != 24'd0) begin
                    coin_cnt[i] <= coin_cnt[i] - 24'd1;
                end
            end
        end
    end

    // Coin buttons stay asserted while their stretch counter is running
    always_comb begin
        btn_out = '0;
        for (int i = 0; i < N_BTN; i++) begin
            btn_out[i] = af_out[i] | (COIN_MASK[i] && (coin_cnt[i] != 24'd0));
        end
    end

    // Registered active-low buttons and the any-button flag
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            btn_l   <= '1;
            btn_any <= 1'b0;
        end else begin
            btn_l   <= ~btn_out;
            btn_any <= |btn_out;
        end
    end

endmodule

// File: tb/tb_arcade_key_mapper.sv
// tb_arcade_key_mapper
// Directed bench: a table of key/joystick vectors applied in a loop, then
// hand-written sequences for priming, latency, clear, coin stretch and
// autofire (plain hold when KEYMAP_AUTOFIRE_EN is not defined).
module tb_arcade_key_mapper;

    localparam int unsigned N_BTN = 8;

    // Slots listed from btn7 slot1 down to btn0 slot0
    localparam logic [159:0] KM = {
        10'h000, 10'h000,   // btn7
        10'h000, 10'h175,   // btn6: extended 75 only
        10'h03A, 10'h000,   // btn5: slot1 shares 3A with btn0
        10'h000, 10'h000,   // btn4: joystick only
        10'h000, 10'h016,   // btn3: autofire button
        10'h000, 10'h021,   // btn2: coin
        10'h01C, 10'h26B,   // btn1: 1C and wildcard 6B
        10'h000, 10'h03A    // btn0
    };
    localparam logic [39:0] JM = {5'd15, 5'h1F, 5'h1F, 5'd4, 5'h1F, 5'h1F, 5'h1F, 5'h1F};

    logic             clk_sys = 1'b0;
    logic             RESET_L;
    logic [10:0]      ps2_key;
    logic [15:0]      joy;
    logic             clr;
    logic             af_en;
    logic [N_BTN-1:0] btn_l;
    logic             btn_any;

    logic strobe;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic       toggle;
        logic       pressed;
        logic [8:0] code;
        logic [15:0] joy;
        logic [7:0] exp_btn_l;
    } vec_t;

    vec_t vecs [15];

    arcade_key_mapper #(
        .N_BTN(N_BTN),
        .KEYMAP(KM),
        .JOYMAP(JM),
        .COIN_MASK(8'h04),
        .COIN_MIN_CYC(100),
        .AF_MASK(8'h08),
        .AF_HALF(10)
    ) dut (
        .clk_sys(clk_sys),
        .RESET_L(RESET_L),
        .ps2_key(ps2_key),
        .joy(joy),
        .clr(clr),
        .af_en(af_en),
        .btn_l(btn_l),
        .btn_any(btn_any)
    );

    // 100 MHz bench clock
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        strobe  = ~strobe;
        ps2_key = {strobe, pressed, code};
    endtask

    task automatic check_output(input string name, input logic [7:0] exp);
        logic exp_any;
        exp_any = (exp != 8'hFF);
        checks++;
        if (btn_l !== exp || btn_any !== exp_any) begin
            errors++;
            $display("[TB] FAIL %s: btn_l=%h btn_any=%b, expected btn_l=%h btn_any=%b",
                     name, btn_l, btn_any, exp, exp_any);
        end
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.toggle) send_key(v.pressed, v.code);
        joy = v.joy;
        tick();
        tick();
    endtask

    initial begin
        int n;
        int bad;
        logic exp_low;

        vecs[0]  = '{1'b1, 1'b1, 9'h03A, 16'h0000, 8'hDE};
        vecs[1]  = '{1'b1, 1'b0, 9'h03A, 16'h0000, 8'hFF};
        vecs[2]  = '{1'b1, 1'b1, 9'h16B, 16'h0000, 8'hFD};
        vecs[3]  = '{1'b1, 1'b1, 9'h01C, 16'h0000, 8'hFD};
        vecs[4]  = '{1'b1, 1'b0, 9'h06B, 16'h0000, 8'hFD};
        vecs[5]  = '{1'b1, 1'b0, 9'h01C, 16'h0000, 8'hFF};
        vecs[6]  = '{1'b1, 1'b1, 9'h075, 16'h0000, 8'hFF};
        vecs[7]  = '{1'b1, 1'b1, 9'h175, 16'h0000, 8'hBF};
        vecs[8]  = '{1'b1, 1'b0, 9'h175, 16'h0000, 8'hFF};
        vecs[9]  = '{1'b1, 1'b1, 9'h055, 16'h0000, 8'hFF};
        vecs[10] = '{1'b0, 1'b0, 9'h000, 16'h0010, 8'hEF};
        vecs[11] = '{1'b0, 1'b0, 9'h000, 16'h8000, 8'h7F};
        vecs[12] = '{1'b0, 1'b0, 9'h000, 16'h0001, 8'hFF};
        vecs[13] = '{1'b1, 1'b1, 9'h016, 16'h0000, 8'hF7};
        vecs[14] = '{1'b1, 1'b0, 9'h016, 16'h0000, 8'hFF};

        // Reset with the strobe high and a mapped press on the bus
        RESET_L = 1'b0;
        strobe  = 1'b1;
        ps2_key = {1'b1, 1'b1, 9'h03A};
        joy     = '0;
        clr     = 1'b0;
        af_en   = 1'b0;
        tick();
        tick();
        check_output("in_reset", 8'hFF);
        RESET_L = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_output("post_reset_no_event", 8'hFF);
        end

        for (int v = 0; v < 15; v++) begin
            apply_stimulus(vecs[v]);
            check_output($sformatf("vec%0d", v), vecs[v].exp_btn_l);
        end

        // Key latency: two edges from strobe to output
        send_key(1'b1, 9'h03A);
        tick();
        check_output("key_lat_1", 8'hFF);
        tick();
        check_output("key_lat_2", 8'hDE);
        send_key(1'b0, 9'h03A);
        tick();
        check_output("key_rel_1", 8'hDE);
        tick();
        check_output("key_rel_2", 8'hFF);

        // Joystick latency: one edge
        joy = 16'h0010;
        tick();
        check_output("joy_lat", 8'hEF);
        joy = 16'h0000;
        tick();
        check_output("joy_rel", 8'hFF);

        // Strobe toggling on consecutive cycles
        send_key(1'b1, 9'h03A);
        tick();
        send_key(1'b1, 9'h01C);
        tick();
        send_key(1'b1, 9'h016);
        tick();
        tick();
        check_output("back_to_back_press", 8'hD4);
        send_key(1'b0, 9'h03A);
        tick();
        send_key(1'b0, 9'h01C);
        tick();
        send_key(1'b0, 9'h016);
        tick();
        tick();
        check_output("back_to_back_release", 8'hFF);

        // Clear drops keys, keeps joystick, swallows a same-cycle event
        send_key(1'b1, 9'h03A);
        joy = 16'h0010;
        tick();
        tick();
        check_output("clr_before", 8'hCE);
        clr = 1'b1;
        send_key(1'b1, 9'h016);
        tick();
        clr = 1'b0;
        check_output("clr_edge_a", 8'hCE);
        tick();
        check_output("clr_edge_b", 8'hEF);
        tick();
        check_output("clr_event_ignored", 8'hEF);
        send_key(1'b0, 9'h03A);
        joy = 16'h0000;
        tick();
        tick();
        check_output("clr_settled", 8'hFF);
        send_key(1'b1, 9'h016);
        tick();
        tick();
        check_output("post_clr_press", 8'hF7);
        send_key(1'b0, 9'h016);
        tick();
        tick();
        check_output("post_clr_release", 8'hFF);

        // Coin stretch on a 3-cycle press
        send_key(1'b1, 9'h021);
        tick();
        check_output("coin_lat", 8'hFF);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (btn_l[2]) break;
            n++;
            if (n == 2) send_key(1'b0, 9'h021);
        end
        check_count("coin_width", n, 100);
        check_output("coin_done", 8'hFF);

        // Re-press during the stretch restarts the full width
        send_key(1'b1, 9'h021);
        tick();
        n = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (btn_l[2]) break;
            n++;
            if (n == 2)  send_key(1'b0, 9'h021);
            if (n == 50) send_key(1'b1, 9'h021);
            if (n == 52) send_key(1'b0, 9'h021);
        end
        check_count("coin_repress_width", n, 151);

        // Autofire button held 45 cycles with af_en set
        af_en = 1'b1;
        send_key(1'b1, 9'h016);
        tick();
        bad = 0;
        for (int j = 0; j < 46; j++) begin
            tick();
`ifdef KEYMAP_AUTOFIRE_EN
            exp_low = (j < 45) && (((j / 10) % 2) == 0);
`else
            exp_low = (j < 45);
`endif
            if (btn_l[3] !== ~exp_low) bad++;
            if (j == 43) send_key(1'b0, 9'h016);
        end
        check_count("af_pattern_mismatches", bad, 0);
        af_en = 1'b0;
        tick();
        check_output("af_released", 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
